// File: rtl/clus_pattern_check.sv
// Pattern checker for the simulated-ROC stream written into ROCFIFO_SIM.
// Parses header/payload events, checks tag sequence and payload pattern, counts events and errors.
module clus_pattern_check #(
    parameter int DIGI_BITS = 32,
    parameter int TAG_BITS  = 20,
    parameter int TIMEOUT   = 1024,
    parameter int CNT_BITS  = 16
) (
    input  logic                 fifoclk,
    input  logic                 fifoclk_reset,
    input  logic                 check_en,
    input  logic                 clear_cnt,
    input  logic                 pattern_type,
    input  logic                 data_we,
    input  logic [DIGI_BITS-1:0] data_in,
    output logic                 event_done,
    output logic                 busy,
    output logic [31:0]          evt_cnt,
    output logic [CNT_BITS-1:0]  tag_err_cnt,
    output logic [CNT_BITS-1:0]  word_err_cnt,
    output logic [CNT_BITS-1:0]  trunc_err_cnt,
    output logic                 err_sticky,
    output logic [DIGI_BITS-1:0] bad_word,
    output logic [DIGI_BITS-1:0] bad_expect
);

    localparam int IDLE_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [IDLE_W-1:0]    IDLE_ONE  = {{(IDLE_W-1){1'b0}}, 1'b1};
    localparam logic [IDLE_W-1:0]    IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [13:0]          LEN_ONE   = 14'd1;
    localparam logic [TAG_BITS-1:0]  TAG_ONE   = {{(TAG_BITS-1){1'b0}}, 1'b1};
    localparam logic [DIGI_BITS-1:0] DAT_ONE   = {{(DIGI_BITS-1){1'b0}}, 1'b1};
    localparam logic [DIGI_BITS-1:0] ALT_5     = {(DIGI_BITS/2){2'b01}};
    localparam logic [DIGI_BITS-1:0] ALT_A     = {(DIGI_BITS/2){2'b10}};
    localparam logic [31:0]          EVT_ONE   = 32'd1;

    typedef enum logic [1:0] {
        ST_WAIT_HDR = 2'd0,
        ST_CHK_DATA = 2'd1,
        ST_EVT_END  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [TAG_BITS-1:0]   tag_q, tag_d;
    logic [13:0]           len_q, len_d;
    logic [13:0]           word_cnt_q, word_cnt_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic [DIGI_BITS-1:0]  exp_cnt_q, exp_cnt_d;
    logic                  alt_phase_q, alt_phase_d;
    logic                  tag_seeded_q, tag_seeded_d;
    logic                  cnt_seeded_q, cnt_seeded_d;
    logic                  alt_seeded_q, alt_seeded_d;

    logic                  event_done_q, busy_q, err_sticky_q;
    logic [31:0]           evt_cnt_q;
    logic [CNT_BITS-1:0]   tag_err_q, word_err_q, trunc_err_q;
    logic [DIGI_BITS-1:0]  bad_word_q, bad_expect_q;

    logic                  hdr_s, tag_inc_s, word_inc_s, trunc_inc_s, evt_inc_s;
    logic [DIGI_BITS-1:0]  exp_val_s;
    logic [TAG_BITS-1:0]   hdr_tag_s;
    logic [13:0]           hdr_len_s;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        logic [CNT_BITS-1:0] one;
        one = {{(CNT_BITS-1){1'b0}}, 1'b1};
        return (&v) ? v : (v + one);
    endfunction

    assign hdr_tag_s = data_in[TAG_BITS-1:0];
    assign hdr_len_s = {data_in[DIGI_BITS-1 -: 12], 2'b00};

    // Next-state, pattern expectation and error-condition decode.
    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        len_d        = len_q;
        word_cnt_d   = word_cnt_q;
        idle_d       = idle_q;
        exp_cnt_d    = exp_cnt_q;
        alt_phase_d  = alt_phase_q;
        tag_seeded_d = tag_seeded_q;
        cnt_seeded_d = cnt_seeded_q;
        alt_seeded_d = alt_seeded_q;
        hdr_s        = 1'b0;
        tag_inc_s    = 1'b0;
        word_inc_s   = 1'b0;
        trunc_inc_s  = 1'b0;
        exp_val_s    = exp_cnt_q;

        if (check_en) begin
            case (state_q)
                ST_WAIT_HDR: begin
                    hdr_s = data_we;
                end
                ST_CHK_DATA: begin
                    if (data_we) begin
                        idle_d = '0;
                        // Next expectation always follows the received word, which resyncs after a mismatch.
                        if (!pattern_type) begin
                            exp_val_s    = exp_cnt_q;
                            word_inc_s   = cnt_seeded_q && (data_in != exp_cnt_q);
                            cnt_seeded_d = 1'b1;
                            exp_cnt_d    = data_in + DAT_ONE;
                        end else begin
                            exp_val_s    = alt_phase_q ? ALT_A : ALT_5;
                            word_inc_s   = alt_seeded_q && (data_in != exp_val_s);
                            alt_seeded_d = 1'b1;
                            alt_phase_d  = (data_in == ALT_5);
                        end
                        if (word_cnt_q == (len_q - LEN_ONE)) begin
                            state_d = ST_EVT_END;
                        end else begin
                            word_cnt_d = word_cnt_q + LEN_ONE;
                        end
                    end else if (idle_q == IDLE_LAST) begin
                        trunc_inc_s = 1'b1;
                        state_d     = ST_WAIT_HDR;
                    end else begin
                        idle_d = idle_q + IDLE_ONE;
                    end
                end
                ST_EVT_END: begin
                    state_d = ST_WAIT_HDR;
                    hdr_s   = data_we;
                end
                default: begin
                    state_d = ST_WAIT_HDR;
                end
            endcase
        end else begin
            state_d = ST_WAIT_HDR;
        end

        if (hdr_s) begin
            tag_inc_s    = tag_seeded_q && (hdr_tag_s != (tag_q + TAG_ONE));
            tag_d        = hdr_tag_s;
            tag_seeded_d = 1'b1;
            len_d        = hdr_len_s;
            word_cnt_d   = '0;
            idle_d       = '0;
            // An empty event still consumes one counter value at the generator.
            if (hdr_len_s == 14'd0) begin
                state_d   = ST_EVT_END;
                exp_cnt_d = exp_cnt_q + DAT_ONE;
            end else begin
                state_d = ST_CHK_DATA;
            end
        end else begin
            tag_d = tag_d;
        end

        if (clear_cnt) begin
            state_d      = ST_WAIT_HDR;
            tag_seeded_d = 1'b0;
            cnt_seeded_d = 1'b0;
            alt_seeded_d = 1'b0;
        end else begin
            state_d = state_d;
        end

        evt_inc_s = (state_d == ST_EVT_END);
    end

    // State, parser context and status flags.
    always_ff @(posedge fifoclk) begin
        if (fifoclk_reset) begin
            state_q      <= ST_WAIT_HDR;
            tag_q        <= '0;
            len_q        <= 14'd0;
            word_cnt_q   <= 14'd0;
            idle_q       <= '0;
            exp_cnt_q    <= '0;
            alt_phase_q  <= 1'b0;
            tag_seeded_q <= 1'b0;
            cnt_seeded_q <= 1'b0;
            alt_seeded_q <= 1'b0;
            event_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            idle_q       <= idle_d;
            exp_cnt_q    <= exp_cnt_d;
            alt_phase_q  <= alt_phase_d;
            tag_seeded_q <= tag_seeded_d;
            cnt_seeded_q <= cnt_seeded_d;
            alt_seeded_q <= alt_seeded_d;
            event_done_q <= evt_inc_s;
            busy_q       <= (state_d != ST_WAIT_HDR);
        end
    end

    // Event/error counters and mismatch capture; clear wins over a same-cycle increment.
    always_ff @(posedge fifoclk) begin
        if (fifoclk_reset || clear_cnt) begin
            evt_cnt_q    <= 32'd0;
            tag_err_q    <= '0;
            word_err_q   <= '0;
            trunc_err_q  <= '0;
            err_sticky_q <= 1'b0;
            bad_word_q   <= '0;
            bad_expect_q <= '0;
        end else begin
            if (evt_inc_s)   evt_cnt_q   <= evt_cnt_q + EVT_ONE;
            if (tag_inc_s)   tag_err_q   <= sat_inc(tag_err_q);
            if (word_inc_s)  word_err_q  <= sat_inc(word_err_q);
            if (trunc_inc_s) trunc_err_q <= sat_inc(trunc_err_q);
            err_sticky_q <= err_sticky_q | tag_inc_s | word_inc_s | trunc_inc_s;
            if (word_inc_s) begin
                bad_word_q   <= data_in;
                bad_expect_q <= exp_val_s;
            end
        end
    end

    assign event_done    = event_done_q;
    assign busy          = busy_q;
    assign evt_cnt       = evt_cnt_q;
    assign tag_err_cnt   = tag_err_q;
    assign word_err_cnt  = word_err_q;
    assign trunc_err_cnt = trunc_err_q;
    assign err_sticky    = err_sticky_q;
    assign bad_word      = bad_word_q;
    assign bad_expect    = bad_expect_q;

endmodule

// File: tb/tb_clus_pattern_check.sv
// Directed self-checking bench for clus_pattern_check; narrow error counters keep saturation short.
module tb_clus_pattern_check;

    localparam int CB = 8;

    logic          fifoclk = 1'b0;
    logic          fifoclk_reset;
    logic          check_en;
    logic          clear_cnt;
    logic          pattern_type;
    logic          data_we;
    logic [31:0]   data_in;
    logic          event_done;
    logic          busy;
    logic [31:0]   evt_cnt;
    logic [CB-1:0] tag_err_cnt;
    logic [CB-1:0] word_err_cnt;
    logic [CB-1:0] trunc_err_cnt;
    logic          err_sticky;
    logic [31:0]   bad_word;
    logic [31:0]   bad_expect;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int d0;

    clus_pattern_check #(.DIGI_BITS(32), .TAG_BITS(20), .TIMEOUT(1024), .CNT_BITS(CB)) dut (
        .fifoclk       (fifoclk),
        .fifoclk_reset (fifoclk_reset),
        .check_en      (check_en),
        .clear_cnt     (clear_cnt),
        .pattern_type  (pattern_type),
        .data_we       (data_we),
        .data_in       (data_in),
        .event_done    (event_done),
        .busy          (busy),
        .evt_cnt       (evt_cnt),
        .tag_err_cnt   (tag_err_cnt),
        .word_err_cnt  (word_err_cnt),
        .trunc_err_cnt (trunc_err_cnt),
        .err_sticky    (err_sticky),
        .bad_word      (bad_word),
        .bad_expect    (bad_expect)
    );

    always #5 fifoclk = ~fifoclk;

    always @(negedge fifoclk) begin
        if (event_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [31:0] w);
        @(posedge fifoclk); #1;
        data_we = 1'b1;
        data_in = w;
        @(posedge fifoclk); #1;
        data_we = 1'b0;
    endtask

    task automatic hdr(input logic [11:0] size, input logic [19:0] tag);
        put({size, tag});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge fifoclk);
        #1;
    endtask

    task automatic pulse_clear();
        @(posedge fifoclk); #1;
        clear_cnt = 1'b1;
        @(posedge fifoclk); #1;
        clear_cnt = 1'b0;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_event_done"}, 32'(event_done), 32'd0);
        chk({pfx, "_busy"},       32'(busy),       32'd0);
        chk({pfx, "_evt_cnt"},    evt_cnt,         32'd0);
        chk({pfx, "_tag_err"},    32'(tag_err_cnt),   32'd0);
        chk({pfx, "_word_err"},   32'(word_err_cnt),  32'd0);
        chk({pfx, "_trunc_err"},  32'(trunc_err_cnt), 32'd0);
        chk({pfx, "_sticky"},     32'(err_sticky), 32'd0);
        chk({pfx, "_bad_word"},   bad_word,        32'd0);
        chk({pfx, "_bad_expect"}, bad_expect,      32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fifoclk_reset = 1'b1;
        check_en      = 1'b1;
        clear_cnt     = 1'b0;
        pattern_type  = 1'b0;
        data_we       = 1'b0;
        data_in       = 32'd0;
        idle(3);
        fifoclk_reset = 1'b0;
        @(negedge fifoclk);
        chk_all_zero("reset");

        // Counter mode, three clean events, contiguous payload 0..23.
        d0 = done_cnt;
        hdr(12'd2, 20'd5);
        @(negedge fifoclk);
        chk("t1_busy_after_hdr", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) put(32'(i));
        @(negedge fifoclk);
        chk("t1_event_done_pulse", 32'(event_done), 32'd1);
        chk("t1_evt_cnt_first", evt_cnt, 32'd1);
        @(negedge fifoclk);
        chk("t1_event_done_low", 32'(event_done), 32'd0);
        hdr(12'd2, 20'd6);
        for (int i = 8; i < 16; i++) put(32'(i));
        hdr(12'd2, 20'd7);
        for (int i = 16; i < 24; i++) put(32'(i));
        idle(2);
        @(negedge fifoclk);
        chk("t1_evt_cnt", evt_cnt, 32'd3);
        chk("t1_tag_err", 32'(tag_err_cnt), 32'd0);
        chk("t1_word_err", 32'(word_err_cnt), 32'd0);
        chk("t1_trunc_err", 32'(trunc_err_cnt), 32'd0);
        chk("t1_sticky", 32'(err_sticky), 32'd0);
        chk("t1_done_pulses", 32'(done_cnt - d0), 32'd3);
        chk("t1_busy_idle", 32'(busy), 32'd0);

        // Alternating mode with one corrupted word and resync.
        pulse_clear();
        pattern_type = 1'b1;
        hdr(12'd1, 20'd0);
        put(32'h5555_5555); put(32'hAAAA_AAAA); put(32'h5555_5555); put(32'hAAAA_AAAA);
        hdr(12'd1, 20'd1);
        put(32'h5555_5555); put(32'hAAAA_AAAA); put(32'h1234_5678); put(32'h5555_5555);
        idle(2);
        @(negedge fifoclk);
        chk("t2_word_err", 32'(word_err_cnt), 32'd1);
        chk("t2_bad_word", bad_word, 32'h1234_5678);
        chk("t2_bad_expect", bad_expect, 32'h5555_5555);
        chk("t2_sticky", 32'(err_sticky), 32'd1);
        chk("t2_tag_err", 32'(tag_err_cnt), 32'd0);
        chk("t2_evt_cnt", evt_cnt, 32'd2);
        hdr(12'd1, 20'd2);
        put(32'hAAAA_AAAA); put(32'h5555_5555); put(32'hAAAA_AAAA); put(32'h5555_5555);
        idle(2);
        @(negedge fifoclk);
        chk("t2_word_err_after", 32'(word_err_cnt), 32'd1);
        chk("t2_evt_cnt_after", evt_cnt, 32'd3);

        // Tag skip, empty event consuming one counter value, ignored header with check_en low.
        pulse_clear();
        pattern_type = 1'b0;
        @(negedge fifoclk);
        chk("t3_clear_evt", evt_cnt, 32'd0);
        chk("t3_clear_sticky", 32'(err_sticky), 32'd0);
        hdr(12'd1, 20'd10);
        for (int i = 0; i < 4; i++) put(32'(i));
        hdr(12'd0, 20'd12);
        @(negedge fifoclk);
        chk("t3_empty_done", 32'(event_done), 32'd1);
        hdr(12'd1, 20'd13);
        for (int i = 5; i < 9; i++) put(32'(i));
        idle(2);
        @(negedge fifoclk);
        chk("t3_tag_err", 32'(tag_err_cnt), 32'd1);
        chk("t3_word_err", 32'(word_err_cnt), 32'd0);
        chk("t3_evt_cnt", evt_cnt, 32'd3);
        check_en = 1'b0;
        hdr(12'd1, 20'd77);
        @(negedge fifoclk);
        chk("t3_disabled_busy", 32'(busy), 32'd0);
        check_en = 1'b1;
        hdr(12'd1, 20'd14);
        for (int i = 9; i < 13; i++) put(32'(i));
        idle(2);
        @(negedge fifoclk);
        chk("t3_tag_err_after_disabled", 32'(tag_err_cnt), 32'd1);
        chk("t3_evt_cnt_after_disabled", evt_cnt, 32'd4);
        chk("t3_word_err_after_disabled", 32'(word_err_cnt), 32'd0);

        // Truncated event: 5 of 8 words then silence.
        pulse_clear();
        hdr(12'd2, 20'd20);
        for (int i = 0; i < 5; i++) put(32'(i));
        idle(1000);
        @(negedge fifoclk);
        chk("t4_busy_before_timeout", 32'(busy), 32'd1);
        chk("t4_trunc_before_timeout", 32'(trunc_err_cnt), 32'd0);
        idle(30);
        @(negedge fifoclk);
        chk("t4_busy_after_timeout", 32'(busy), 32'd0);
        chk("t4_trunc_err", 32'(trunc_err_cnt), 32'd1);
        chk("t4_evt_cnt", evt_cnt, 32'd0);
        chk("t4_sticky", 32'(err_sticky), 32'd1);
        hdr(12'd1, 20'd21);
        for (int i = 5; i < 9; i++) put(32'(i));
        idle(2);
        @(negedge fifoclk);
        chk("t4_next_evt_cnt", evt_cnt, 32'd1);
        chk("t4_next_word_err", 32'(word_err_cnt), 32'd0);
        chk("t4_next_tag_err", 32'(tag_err_cnt), 32'd0);
        chk("t4_next_trunc_hold", 32'(trunc_err_cnt), 32'd1);

        // Saturation: 257 mismatches on an 8-bit counter, then clear mid-event.
        pulse_clear();
        pattern_type = 1'b1;
        hdr(12'h041, 20'd30);
        for (int i = 0; i < 258; i++) put(32'h1234_5678);
        @(negedge fifoclk);
        chk("t5_word_err_sat", 32'(word_err_cnt), 32'h0000_00FF);
        chk("t5_bad_word", bad_word, 32'h1234_5678);
        chk("t5_bad_expect", bad_expect, 32'h5555_5555);
        chk("t5_busy_mid", 32'(busy), 32'd1);
        chk("t5_sticky", 32'(err_sticky), 32'd1);
        pulse_clear();
        @(negedge fifoclk);
        chk_all_zero("t5_clear");
        hdr(12'd0, 20'd99);
        @(negedge fifoclk);
        chk("t5_reseed_done", 32'(event_done), 32'd1);
        chk("t5_reseed_tag_err", 32'(tag_err_cnt), 32'd0);
        chk("t5_reseed_evt", evt_cnt, 32'd1);

        // Reset in the middle of a payload, then a clean event.
        pulse_clear();
        pattern_type = 1'b0;
        hdr(12'd0, 20'd39);
        hdr(12'd0, 20'd45);
        hdr(12'd1, 20'd46);
        put(32'd0);
        put(32'd1);
        @(negedge fifoclk);
        chk("t6_pre_busy", 32'(busy), 32'd1);
        chk("t6_pre_tag_err", 32'(tag_err_cnt), 32'd1);
        chk("t6_pre_evt", evt_cnt, 32'd2);
        @(posedge fifoclk); #1;
        fifoclk_reset = 1'b1;
        @(posedge fifoclk); #1;
        @(negedge fifoclk);
        chk_all_zero("t6_reset");
        fifoclk_reset = 1'b0;
        hdr(12'd1, 20'd50);
        for (int i = 77; i < 81; i++) put(32'(i));
        idle(2);
        @(negedge fifoclk);
        chk("t6_post_evt", evt_cnt, 32'd1);
        chk("t6_post_word_err", 32'(word_err_cnt), 32'd0);
        chk("t6_post_tag_err", 32'(tag_err_cnt), 32'd0);
        chk("t6_post_sticky", 32'(err_sticky), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
